bit_serializer: RTL and testbench



---
 rtl/bit_serializer.sv | 105 ++++++++++
 tb/tb_bit_serializer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit per enabled clock out.
// Define SER_FV_EN to compile the embedded SVA checks and covers.
module bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic             ser_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [CW-1:0]    r_bit_cnt;
  logic [CW-1:0]    w_bit_cnt_nxt;
  logic             r_word_done;
  logic             w_word_done_nxt;
  logic             w_accept;
  logic             w_last;

  assign w_last     = (r_bit_cnt == '0);
  assign busy       = (r_state == SHIFT);
  assign ser_valid  = busy && ser_en;
  assign data_ready = (r_state == IDLE) || (busy && w_last && ser_en);
  assign w_accept   = data_valid && data_ready;
  assign ser_out    = busy ? (MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0]) : 1'b0;
  assign word_done  = r_word_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_word_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_word_done <= w_word_done_nxt;
    end
  end

  // An accept on the last-bit edge overrides the return to IDLE, giving bubble-free back-to-back words.
  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_word_done_nxt = 1'b0;
    if (ser_valid) begin
      if (!w_last) begin
        w_shift_nxt   = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};
        w_bit_cnt_nxt = r_bit_cnt - 1'b1;
      end else begin
        w_word_done_nxt = 1'b1;
        w_state_nxt     = IDLE;
      end
    end
    if (w_accept) begin
      w_shift_nxt   = data_in;
      w_bit_cnt_nxt = CW'(WIDTH - 1);
      w_state_nxt   = SHIFT;
    end
  end

`ifdef SER_FV_EN
  // Valid bits seen since the previous word_done; must equal WIDTH whenever word_done fires.
  logic [6:0] r_fv_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fv_cnt <= '0;
    else        r_fv_cnt <= (word_done ? 7'd0 : r_fv_cnt) + {6'd0, ser_valid};
  end

  default clocking fv_cb @(posedge clk); endclocking
  default disable iff (!rst_n);

  a_valid_busy:   assert property (ser_valid |-> busy);
  a_word_len:     assert property (word_done |-> (r_fv_cnt == 7'(WIDTH)));
  a_done_single:  assert property (word_done |=> !word_done);

  c_prod_change:  cover property ((data_valid && !data_ready) ##1 !$stable(data_in));
  c_back2back:    cover property (ser_valid && w_last && w_accept);
  c_mid_stall:    cover property (busy && !ser_en && (r_bit_cnt != CW'(WIDTH - 1)));
  c_11001:        cover property (MSB_FIRST && ser_valid && ser_out ##1 ser_valid && ser_out
                                  ##1 ser_valid && !ser_out ##1 ser_valid && !ser_out
                                  ##1 ser_valid && ser_out);
`endif

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: MSB-first and LSB-first instances, queue scoreboard of serial bits.
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a_data_in, b_data_in;
  logic       a_data_valid, b_data_valid;
  logic       a_data_ready, b_data_ready;
  logic       a_ser_en, b_ser_en;
  logic       a_ser_out, b_ser_out;
  logic       a_ser_valid, b_ser_valid;
  logic       a_busy, b_busy;
  logic       a_word_done, b_word_done;

  int tests = 0;
  int fails = 0;

  logic qa[$];
  logic qb[$];

  logic [4:0] det_hist = '0;
  int         det_idx  = 0;
  int         det_hits = 0;
  int         det_pos  = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .data_in(a_data_in), .data_valid(a_data_valid),
    .data_ready(a_data_ready), .ser_en(a_ser_en), .ser_out(a_ser_out),
    .ser_valid(a_ser_valid), .busy(a_busy), .word_done(a_word_done)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .data_in(b_data_in), .data_valid(b_data_valid),
    .data_ready(b_data_ready), .ser_en(b_ser_en), .ser_out(b_ser_out),
    .ser_valid(b_ser_valid), .busy(b_busy), .word_done(b_word_done)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [7:0] d);
    for (int i = 0; i < 8; i++) qa.push_back(d[7-i]);
  endtask

  task automatic push_b(input logic [7:0] d);
    for (int i = 0; i < 8; i++) qb.push_back(d[i]);
  endtask

  task automatic sb_a();
    logic e;
    if (a_ser_valid) begin
      chk("a_sb_has_entry", qa.size() != 0, 1'b1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        chk("a_ser_out", a_ser_out, e);
      end
    end
  endtask

  task automatic sb_b();
    logic e;
    if (b_ser_valid) begin
      chk("b_sb_has_entry", qb.size() != 0, 1'b1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        chk("b_ser_out", b_ser_out, e);
      end
      det_idx++;
      det_hist = {det_hist[3:0], b_ser_out};
      if (det_idx >= 5 && det_hist == 5'b11001) begin
        det_hits++;
        det_pos = det_idx;
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #1;
    sb_a();
    sb_b();
  endtask

  task automatic chk_a_reset_vals(input string tag);
    chk({tag, "_ready"}, a_data_ready, 1'b1);
    chk({tag, "_busy"},  a_busy,       1'b0);
    chk({tag, "_valid"}, a_ser_valid,  1'b0);
    chk({tag, "_out"},   a_ser_out,    1'b0);
    chk({tag, "_done"},  a_word_done,  1'b0);
  endtask

  initial begin
    rst_n = 1'b1;
    a_data_in = '0; a_data_valid = 1'b0; a_ser_en = 1'b1;
    b_data_in = '0; b_data_valid = 1'b0; b_ser_en = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk_a_reset_vals("rst0");
    chk("rst0_b_ready", b_data_ready, 1'b1);
    next_cycle(); look();
    next_cycle(); rst_n = 1'b1; look();
    next_cycle(); look();

    // Single word, MSB first
    a_data_in = 8'hC8; a_data_valid = 1'b1;
    look();
    chk("t1_ready_c0", a_data_ready, 1'b1);
    push_a(8'hC8);
    for (int c = 1; c <= 9; c++) begin
      next_cycle(); a_data_valid = 1'b0; look();
      if (c <= 8) begin
        chk("t1_valid", a_ser_valid, 1'b1);
        chk("t1_busy",  a_busy,      1'b1);
        chk("t1_ready", a_data_ready, c == 8);
        chk("t1_done",  a_word_done, 1'b0);
      end else begin
        chk("t1_done_c9",  a_word_done,  1'b1);
        chk("t1_busy_c9",  a_busy,       1'b0);
        chk("t1_ready_c9", a_data_ready, 1'b1);
        chk("t1_valid_c9", a_ser_valid,  1'b0);
      end
    end
    chk_int("t1_drained", qa.size(), 0);
    next_cycle(); look();
    chk("t1_done_c10", a_word_done, 1'b0);

    // LSB first into a downstream 11001 detector
    b_data_in = 8'h13; b_data_valid = 1'b1;
    look();
    chk("t2_ready_c0", b_data_ready, 1'b1);
    push_b(8'h13);
    for (int c = 1; c <= 9; c++) begin
      next_cycle(); b_data_valid = 1'b0; look();
      chk("t2_valid", b_ser_valid, c <= 8);
      chk("t2_done",  b_word_done, c == 9);
    end
    chk_int("t2_drained", qb.size(), 0);
    chk_int("t2_det_hits", det_hits, 1);
    chk_int("t2_det_pos",  det_pos,  5);

    // Back-to-back words with data_valid held high
    a_data_in = 8'hC8; a_data_valid = 1'b1;
    look();
    chk("t3_ready_c0", a_data_ready, 1'b1);
    push_a(8'hC8);
    for (int c = 1; c <= 17; c++) begin
      next_cycle();
      if (c == 1) a_data_in = 8'hFF;
      if (c == 9) a_data_valid = 1'b0;
      look();
      if (c == 8) push_a(8'hFF);
      if (c <= 16) begin
        chk("t3_valid", a_ser_valid, 1'b1);
        chk("t3_ready", a_data_ready, (c == 8) || (c == 16));
        chk("t3_done",  a_word_done, c == 9);
      end else begin
        chk("t3_done_c17", a_word_done, 1'b1);
        chk("t3_busy_c17", a_busy,      1'b0);
      end
    end
    chk_int("t3_drained", qa.size(), 0);

    // Consumer stall on cycles 3..5
    next_cycle(); a_data_in = 8'hC8; a_data_valid = 1'b1;
    look();
    push_a(8'hC8);
    for (int c = 1; c <= 12; c++) begin
      next_cycle();
      a_data_valid = 1'b0;
      a_ser_en = !(c >= 3 && c <= 5);
      look();
      if (c >= 3 && c <= 5) begin
        chk("t4_stall_valid", a_ser_valid,  1'b0);
        chk("t4_stall_out",   a_ser_out,    1'b0);
        chk("t4_stall_ready", a_data_ready, 1'b0);
        chk("t4_stall_busy",  a_busy,       1'b1);
      end else if (c <= 11) begin
        chk("t4_valid", a_ser_valid, 1'b1);
        chk("t4_done",  a_word_done, 1'b0);
      end else begin
        chk("t4_done_c12", a_word_done, 1'b1);
        chk("t4_busy_c12", a_busy,      1'b0);
      end
    end
    chk_int("t4_drained", qa.size(), 0);

    // Asynchronous reset in the middle of cycle 4
    next_cycle(); a_data_in = 8'hC8; a_data_valid = 1'b1;
    look();
    push_a(8'hC8);
    for (int c = 1; c <= 3; c++) begin
      next_cycle(); a_data_valid = 1'b0; look();
      chk("t5_valid", a_ser_valid, 1'b1);
    end
    next_cycle();
    #2 rst_n = 1'b0;
    #1;
    chk_a_reset_vals("t5_async");
    qa.delete();
    next_cycle(); look();
    next_cycle(); rst_n = 1'b1; look();
    chk("t5_ready_after", a_data_ready, 1'b1);

    // Idle for 20 cycles after reset
    for (int c = 0; c < 20; c++) begin
      next_cycle(); look();
      chk("t6_busy",  a_busy,      1'b0);
      chk("t6_valid", a_ser_valid, 1'b0);
      chk("t6_out",   a_ser_out,   1'b0);
      chk("t6_done",  a_word_done, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
